// File: rtl/axi_b_resp_queue.sv
// axi_b_resp_queue: merges per-beat write completions into one AXI B response per burst
// and queues the responses in a small flushable FIFO toward the master.
module axi_b_resp_queue #(
  parameter int unsigned IdWidth = 4,
  parameter int unsigned UserWidth = 1,
  parameter int unsigned Depth = 2,
  localparam int unsigned UsageWidth = $clog2(Depth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  beat_valid_i,
  output logic                  beat_ready_o,
  input  logic                  beat_last_i,
  input  logic [IdWidth-1:0]    beat_id_i,
  input  logic [1:0]            beat_resp_i,
  input  logic [UserWidth-1:0]  beat_user_i,
  output logic                  b_valid_o,
  input  logic                  b_ready_i,
  output logic [IdWidth-1:0]    b_id_o,
  output logic [1:0]            b_resp_o,
  output logic [UserWidth-1:0]  b_user_o,
  output logic [UsageWidth-1:0] usage_o,
  output logic                  busy_o
);
  localparam int unsigned PtrWidth = Depth > 1 ? $clog2(Depth) : 1;
  localparam int unsigned EntryWidth = IdWidth + 2 + UserWidth;
  // Severity rank: EXOKAY < OKAY < SLVERR < DECERR
  function automatic logic [1:0] rank(input logic [1:0] r);
    return r[1] ? r : {1'b0, ~r[0]};
  endfunction
  logic [EntryWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0]   wptr_q, rptr_q;
  logic [UsageWidth-1:0] usage_q;
  logic                  acc_valid_q;
  logic [1:0]            acc_resp_q, merged;
  logic                  full, empty, accept, push, pop;
  assign full = usage_q == UsageWidth'(Depth);
  assign empty = usage_q == '0;
  assign beat_ready_o = !full && !flush_i;
  assign accept = beat_valid_i && beat_ready_o;
  assign push = accept && beat_last_i;
  assign b_valid_o = !empty && !flush_i;
  assign pop = b_valid_o && b_ready_i;
  assign merged = acc_valid_q && rank(acc_resp_q) > rank(beat_resp_i) ? acc_resp_q : beat_resp_i;
  assign {b_id_o, b_resp_o, b_user_o} = mem_q[rptr_q];
  assign usage_o = usage_q;
  assign busy_o = acc_valid_q || !empty;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      usage_q <= '0;
      acc_valid_q <= 1'b0;
      acc_resp_q <= 2'b00;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      usage_q <= '0;
      acc_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        acc_valid_q <= !beat_last_i;
        acc_resp_q <= merged;
      end
      if (push) begin
        mem_q[wptr_q] <= {beat_id_i, merged, beat_user_i};
        wptr_q <= wptr_q == PtrWidth'(Depth - 1) ? '0 : wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q == PtrWidth'(Depth - 1) ? '0 : rptr_q + 1'b1;
      usage_q <= usage_q + UsageWidth'(push) - UsageWidth'(pop);
    end
  end
endmodule

// File: tb/tb_axi_b_resp_queue.sv
// tb_axi_b_resp_queue: directed checks of burst merging, FIFO ordering, flush and reset.
module tb_axi_b_resp_queue;
  logic clk_i = 1'b0, rst_ni = 1'b0, flush_i = 1'b0;
  logic beat_valid_i = 1'b0, beat_last_i = 1'b0, beat_ready_o;
  logic [3:0] beat_id_i = '0, b_id_o;
  logic [1:0] beat_resp_i = '0, b_resp_o, usage_o;
  logic [0:0] beat_user_i = '0, b_user_o;
  logic b_valid_o, b_ready_i = 1'b0, busy_o;
  int total = 0, bad = 0;
  axi_b_resp_queue dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .beat_valid_i(beat_valid_i), .beat_ready_o(beat_ready_o), .beat_last_i(beat_last_i),
    .beat_id_i(beat_id_i), .beat_resp_i(beat_resp_i), .beat_user_i(beat_user_i),
    .b_valid_o(b_valid_o), .b_ready_i(b_ready_i), .b_id_o(b_id_o), .b_resp_o(b_resp_o),
    .b_user_o(b_user_o), .usage_o(usage_o), .busy_o(busy_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic last, input logic [3:0] id, input logic [1:0] resp, input logic user);
    beat_valid_i = 1'b1;
    beat_last_i = last;
    beat_id_i = id;
    beat_resp_i = resp;
    beat_user_i = user;
    @(posedge clk_i);
    #1;
    beat_valid_i = 1'b0;
  endtask
  task automatic pop_one;
    b_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    b_ready_i = 1'b0;
  endtask
  task automatic burst(input string tag, input logic [1:0] r0, input logic [1:0] r1, input logic [1:0] exp);
    send(1'b0, 4'd2, r0, 1'b0);
    send(1'b1, 4'd2, r1, 1'b1);
    check({tag, "_valid"}, b_valid_o, 1);
    check({tag, "_resp"}, b_resp_o, exp);
    pop_one();
  endtask
  initial begin
    #1;
    check("rst_ready", beat_ready_o, 1);
    check("rst_bvalid", b_valid_o, 0);
    check("rst_bfields", {b_id_o, b_resp_o, b_user_o}, 0);
    check("rst_usage", usage_o, 0);
    check("rst_busy", busy_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    // single beat
    b_ready_i = 1'b1;
    send(1'b1, 4'd3, 2'b00, 1'b1);
    check("single_valid", b_valid_o, 1);
    check("single_id", b_id_o, 3);
    check("single_resp", b_resp_o, 0);
    check("single_user", b_user_o, 1);
    @(posedge clk_i);
    #1;
    check("single_usage", usage_o, 0);
    check("single_drain", b_valid_o, 0);
    b_ready_i = 1'b0;
    // 4-beat burst
    send(1'b0, 4'd5, 2'b00, 1'b0);
    send(1'b0, 4'd5, 2'b10, 1'b0);
    send(1'b0, 4'd5, 2'b00, 1'b0);
    check("b4_early", b_valid_o, 0);
    check("b4_busy", busy_o, 1);
    send(1'b1, 4'd5, 2'b01, 1'b0);
    check("b4_valid", b_valid_o, 1);
    check("b4_id", b_id_o, 5);
    check("b4_resp", b_resp_o, 2);
    check("b4_usage", usage_o, 1);
    pop_one();
    check("b4_once", usage_o, 0);
    burst("exex", 2'b01, 2'b01, 2'b01);
    burst("exok", 2'b01, 2'b00, 2'b00);
    burst("dec", 2'b11, 2'b00, 2'b11);
    burst("slv_ex", 2'b10, 2'b01, 2'b10);
    send(1'b1, 4'd6, 2'b01, 1'b0);
    check("single_ex", b_resp_o, 1);
    pop_one();
    // fill Depth=2 and stall
    send(1'b1, 4'd1, 2'b00, 1'b0);
    send(1'b1, 4'd2, 2'b00, 1'b0);
    check("full_usage", usage_o, 2);
    check("full_ready", beat_ready_o, 0);
    beat_valid_i = 1'b1; beat_last_i = 1'b1; beat_id_i = 4'd3; beat_resp_i = 2'b00;
    @(posedge clk_i);
    #1;
    check("stall_usage", usage_o, 2);
    check("order_1", b_id_o, 1);
    b_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("pop_no_push", usage_o, 1);
    check("order_2", b_id_o, 2);
    check("ready_back", beat_ready_o, 1);
    @(posedge clk_i);
    #1;
    beat_valid_i = 1'b0;
    check("pushpop_usage", usage_o, 1);
    check("order_3", b_id_o, 3);
    @(posedge clk_i);
    #1;
    b_ready_i = 1'b0;
    check("drained", usage_o, 0);
    // flush mid-burst with one entry queued
    send(1'b1, 4'd9, 2'b00, 1'b0);
    send(1'b0, 4'd8, 2'b11, 1'b0);
    send(1'b0, 4'd8, 2'b11, 1'b0);
    flush_i = 1'b1;
    b_ready_i = 1'b1;
    #1;
    check("flush_ready", beat_ready_o, 0);
    check("flush_bvalid", b_valid_o, 0);
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    b_ready_i = 1'b0;
    check("flush_usage", usage_o, 0);
    check("flush_valid", b_valid_o, 0);
    check("flush_busy", busy_o, 0);
    send(1'b1, 4'd7, 2'b00, 1'b0);
    check("post_flush_id", b_id_o, 7);
    check("post_flush_resp", b_resp_o, 0);
    pop_one();
    // async reset with 2 queued and a partial burst
    send(1'b1, 4'd1, 2'b00, 1'b0);
    send(1'b0, 4'd4, 2'b11, 1'b0);
    send(1'b1, 4'd2, 2'b00, 1'b0);
    send(1'b0, 4'd4, 2'b11, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_valid", b_valid_o, 0);
    check("arst_usage", usage_o, 0);
    check("arst_busy", busy_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    send(1'b1, 4'd4, 2'b01, 1'b0);
    check("arst_after_id", b_id_o, 4);
    check("arst_after_resp", b_resp_o, 1);
    check("arst_after_usage", usage_o, 1);
    pop_one();
    check("arst_after_drain", usage_o, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
